// File: rtl/tdm_burst_scheduler_if.sv
// rtl/tdm_burst_scheduler_if.sv - lane inputs and TDM link outputs of the burst scheduler
interface tdm_burst_scheduler_if;
  logic [7:0] i_din0;
  logic       i_din0_valid;
  logic [7:0] i_din1;
  logic       i_din1_valid;
  logic [7:0] o_dout;
  logic       o_dout_valid;
  logic       o_dout_ch;
  logic       o_slot_start;
  logic [1:0] o_ovf;

  modport master (
    output i_din0, i_din0_valid, i_din1, i_din1_valid,
    input  o_dout, o_dout_valid, o_dout_ch, o_slot_start, o_ovf
  );

  modport slave (
    input  i_din0, i_din0_valid, i_din1, i_din1_valid,
    output o_dout, o_dout_valid, o_dout_ch, o_slot_start, o_ovf
  );
endinterface

// File: rtl/tdm_burst_scheduler.sv
// rtl/tdm_burst_scheduler.sv - two-lane burst merger onto a slotted TDM link
// Work-conserving slots (an empty lane ends its slot early) when TDM_SKIP_EMPTY_EN is defined.
module tdm_burst_scheduler #(
  parameter int DEPTH     = 8,
  parameter int SLOT_LEN  = 4,
  parameter int GUARD_LEN = 1
) (
  input  logic                 i_ss_clk,
  input  logic                 i_rst,
  tdm_burst_scheduler_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLEN = (SLOT_LEN > GUARD_LEN) ? SLOT_LEN : GUARD_LEN;
  localparam int CW     = $clog2(MAXLEN) + 1;
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_LEN - 1);

  typedef enum logic [1:0] {SLOT0, GAP0, SLOT1, GAP1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    slot_end;

  logic [7:0]    mem    [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   count  [2];
  logic [7:0]    din    [2];
  logic [1:0]    din_valid, full, push, pop;

  logic [7:0] dout_q;
  logic       dout_valid_q, dout_ch_q, slot_start_q, rst_q;
  logic [1:0] ovf_q;

  assign din[0]    = bus.i_din0;
  assign din[1]    = bus.i_din1;
  assign din_valid = {bus.i_din1_valid, bus.i_din0_valid};
  assign full      = {count[1] == FULL_CNT, count[0] == FULL_CNT};
  assign pop[0]    = (state == SLOT0) && (count[0] != '0);
  assign pop[1]    = (state == SLOT1) && (count[1] != '0);
  // A full FIFO still takes the word when the same cycle pops one out.
  assign push      = din_valid & (~full | pop);

`ifdef TDM_SKIP_EMPTY_EN
  assign slot_end[0] = (cnt == SLOT_LAST) || (count[0] == '0);
  assign slot_end[1] = (cnt == SLOT_LAST) || (count[1] == '0);
`else
  assign slot_end[0] = (cnt == SLOT_LAST);
  assign slot_end[1] = (cnt == SLOT_LAST);
`endif

  always_ff @(posedge i_ss_clk) begin
    if (i_rst) begin
      state <= SLOT0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      SLOT0: if (slot_end[0]) begin
        state_nxt = GAP0;
        cnt_nxt   = '0;
      end
      GAP0: if (cnt == GUARD_LAST) begin
        state_nxt = SLOT1;
        cnt_nxt   = '0;
      end
      SLOT1: if (slot_end[1]) begin
        state_nxt = GAP1;
        cnt_nxt   = '0;
      end
      GAP1: if (cnt == GUARD_LAST) begin
        state_nxt = SLOT0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_ss_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem[n][wr_ptr[n]] <= din[n];
    end
  end

  always_ff @(posedge i_ss_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + AW'(1);
        count[n] <= count[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
      end
      ovf_q <= ovf_q | (din_valid & full & ~pop);
    end
  end

  always_ff @(posedge i_ss_clk) begin
    if (i_rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_ch_q    <= 1'b0;
      slot_start_q <= 1'b0;
    end else begin
      dout_valid_q <= |pop;
      if (pop[0]) begin
        dout_q    <= mem[0][rd_ptr[0]];
        dout_ch_q <= 1'b0;
      end else if (pop[1]) begin
        dout_q    <= mem[1][rd_ptr[1]];
        dout_ch_q <= 1'b1;
      end
      slot_start_q <= ((state_nxt == SLOT0) || (state_nxt == SLOT1)) && (state_nxt != state);
    end
  end

  always_ff @(posedge i_ss_clk) begin
    rst_q <= i_rst;
  end

  // The post-reset slot0 is entered by reset, not by a transition, so flag it from rst_q.
  assign bus.o_slot_start = slot_start_q | (rst_q & ~i_rst);
  assign bus.o_dout       = dout_q;
  assign bus.o_dout_valid = dout_valid_q;
  assign bus.o_dout_ch    = dout_ch_q;
  assign bus.o_ovf        = ovf_q;
endmodule
